chrow_renderer: RTL
===================

// Module: chrow_renderer
// PURPOSE
//  Reader side of the character row buffer. On a start pulse, fetches NUM_COLS
//  attr/code pairs for the current character row and looks up each glyph
//  scanline in the font ROM. Writes one 4-bit colour index per pixel into the
//  scanline pixel buffer, ready for the VGA output stage.
// PARAMETERS
//  NUM_COLS  100  characters per row (1..256)
//  CHAR_W    8    pixels per glyph scanline (3..8; font byte MSB = leftmost pixel)
//  CHAR_H    16   scanlines per glyph; font address = {code[7:0], scanline[3:0]}
//  PB_AW     10   pixel buffer address width (must hold NUM_COLS*CHAR_W)
// PORTS
//  clk           in   1      system clock
//  rst           in   1      synchronous reset, active-high
//  start         in   1      1-cycle pulse: render one row; ignored while busy
//  scanline      in   4      glyph scanline to render; sampled with start
//  busy          out  1      1 from cycle after start accepted until done
//  done          out  1      1-cycle pulse, cycle after the last pixel write
//  cr_rd         out  1      char row buffer read strobe, 0=read
//  cr_rd_addr    out  8      column being fetched
//  cr_rd_data    in   16     [15:8]=attr, [7:0]=code; valid 1 cycle after cr_rd=0
//  font_rd       out  1      font ROM read strobe, 0=read
//  font_rd_addr  out  12     {code, scanline}
//  font_rd_data  in   8      glyph bits; valid 1 cycle after font_rd=0
//  pb_wr         out  1      pixel buffer write strobe, 0=write
//  pb_wr_addr    out  PB_AW  pixel index = col*CHAR_W + px
//  pb_wr_data    out  4      colour index
// BEHAVIOUR
//  - Reset: busy=0, done=0, cr_rd=1, font_rd=1, pb_wr=1, all addresses/data=0,
//    FSM=IDLE. Reset mid-row aborts: no further strobes after the reset edge.
//  - FSM: IDLE -> PRIME (first fetch + font lookup) -> EMIT (pixels) -> IDLE.
//    No done pulse follows an aborted row.
//  - Start accepted in IDLE at edge T: scanline latched; cr_rd=0, addr 0 at T+1.
//    T+2: code captured; font_rd=0 with {code0, scanline}.
//    T+3: glyph + attr loaded into the shifter.
//    T+4: first pb_wr=0 at addr 0.
//  - EMIT: exactly one pixel write per cycle, NUM_COLS*CHAR_W consecutive
//    cycles, addresses strictly incrementing, no bubbles.
//  - Prefetch: the next column's cr read is issued so its glyph is loaded on
//    the cycle after the current char's last pixel. Issue point: px==CHAR_W-3
//    of current char. No fetch beyond column NUM_COLS-1.
//  - Colour: bit=1 -> attr[3:0] (fg), bit=0 -> attr[7:4] (bg).
//    Glyph bits used MSB-first: font_rd_data[7 - px].
//  - done=1 and busy=0 together, one cycle after the final write. Total: start
//    edge to done = NUM_COLS*CHAR_W + 4 cycles. IDLE re-entered same cycle; a
//    start in the done cycle is accepted.
//  - start while busy: dropped. No queueing, no effect on current row.
//  - Strobes are registered outputs; addresses are held stable while a strobe is 0.
// STRUCTURE
//  - Shared include vga_defs.vh:
//    - ATTR_FG/ATTR_BG/CODE field ranges
//    - STROBE_ON=1'b0 / STROBE_OFF=1'b1
//    - default NUM_COLS/CHAR_W/CHAR_H
//  - Sub-module glyph_shifter: loads {attr, glyph} on load and steps one pixel
//    per cycle. Outputs colour index and last_px flag.
//  - Parent holds FSM, column/pixel counters, fetch sequencing.
// TESTING
//  1. Buffer col0={8'h1E,8'h41}, font[{8'h41,4'd3}]=8'b1000_0001, scanline=3,
//     NUM_COLS=1 -> 8 writes addr 0..7, data E,1,1,1,1,1,1,E; done at T+12.
//  2. Default 100 cols, sequential codes -> 800 back-to-back writes addr 0..799,
//     no gap cycles; cr_rd_addr 0..99 each read once; done exactly once.
//  3. start pulsed again 50 cycles into a row -> ignored: write count stays 800,
//     scanline unchanged, single done.
//  4. rst asserted at write #300 -> from the next cycle cr_rd=font_rd=pb_wr=1,
//     busy=0, no done. Fresh start renders full row from addr 0.
//  5. start in the done cycle -> second row starts immediately; first write of
//     row 2 is 4 cycles later.
//  6. CHAR_W=3, NUM_COLS=256, PB_AW=10 -> 768 contiguous writes, last addr 767,
//     prefetch never stalls.

Source files
------------

// File: rtl/chrow_renderer_pkg.sv
// Shared definitions for the character-row renderer: attr/code field ranges,
// strobe levels, default geometry and the FSM state type.
package chrow_renderer_pkg;

    localparam int DEF_NUM_COLS = 100;
    localparam int DEF_CHAR_W   = 8;
    localparam int DEF_CHAR_H   = 16;
    localparam int DEF_PB_AW    = 10;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    localparam int ATTR_MSB = 15;
    localparam int ATTR_LSB = 8;
    localparam int CODE_MSB = 7;
    localparam int CODE_LSB = 0;
    localparam int FG_MSB   = 3;
    localparam int FG_LSB   = 0;
    localparam int BG_MSB   = 7;
    localparam int BG_LSB   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_EMIT
    } state_t;

    function automatic logic [3:0] pixel_colour(input logic [7:0] attr, input logic bit_on);
        return bit_on ? attr[FG_MSB:FG_LSB] : attr[BG_MSB:BG_LSB];
    endfunction

endpackage

// File: rtl/chrow_renderer_glyph_shifter.sv
// Per-character pixel shifter: loads {attr, glyph} and presents one colour
// index per cycle, MSB-first, flagging the last pixel of the glyph.
module glyph_shifter
    import chrow_renderer_pkg::*;
#(
    parameter int CHAR_W = DEF_CHAR_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] attr,
    input  logic [7:0] glyph,
    output logic [3:0] colour,
    output logic       last_px
);

    localparam logic [3:0] LAST_IDX = 4'(CHAR_W - 1);

    logic [7:0] bits;
    logic [7:0] attr_q;
    logic [3:0] px;

    // The first pixel is produced straight from the load inputs so the
    // colour register is valid on the same edge the glyph arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            bits    <= '0;
            attr_q  <= '0;
            px      <= '0;
            colour  <= '0;
            last_px <= 1'b1;
        end else if (load) begin
            colour  <= pixel_colour(attr, glyph[7]);
            bits    <= {glyph[6:0], 1'b0};
            attr_q  <= attr;
            px      <= '0;
            last_px <= 1'b0;
        end else if (!last_px) begin
            colour  <= pixel_colour(attr_q, bits[7]);
            bits    <= {bits[6:0], 1'b0};
            px      <= px + 4'd1;
            last_px <= ((px + 4'd1) == LAST_IDX);
        end
    end

endmodule

// File: rtl/chrow_renderer.sv
// Character row renderer: fetches attr/code per column, looks up the glyph
// scanline and streams one colour index per cycle into the pixel buffer.
module chrow_renderer
    import chrow_renderer_pkg::*;
#(
    parameter int NUM_COLS = DEF_NUM_COLS,
    parameter int CHAR_W   = DEF_CHAR_W,
    parameter int CHAR_H   = DEF_CHAR_H,
    parameter int PB_AW    = DEF_PB_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       scanline,
    output logic             busy,
    output logic             done,
    output logic             cr_rd,
    output logic [7:0]       cr_rd_addr,
    input  logic [15:0]      cr_rd_data,
    output logic             font_rd,
    output logic [11:0]      font_rd_addr,
    input  logic [7:0]       font_rd_data,
    output logic             pb_wr,
    output logic [PB_AW-1:0] pb_wr_addr,
    output logic [3:0]       pb_wr_data
);

    localparam logic [8:0] COLS       = 9'(NUM_COLS);
    localparam logic [7:0] LAST_COL   = 8'(NUM_COLS - 1);
    localparam logic [3:0] GAP_RELOAD = 4'(CHAR_W - 1);
    localparam logic [3:0] SL_MASK    = 4'(CHAR_H - 1);

    state_t     state;
    logic [3:0] scan_q;
    logic [8:0] fcol;
    logic [3:0] gap;
    logic       fetch_p1;
    logic       fetch_p2;
    logic       fetch_p3;
    logic       glyph_load;
    logic [7:0] attr_q;
    logic [7:0] emit_col;
    logic       last_px;

    glyph_shifter #(
        .CHAR_W (CHAR_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (glyph_load),
        .attr    (attr_q),
        .glyph   (font_rd_data),
        .colour  (pb_wr_data),
        .last_px (last_px)
    );

    // Column reads are issued every CHAR_W cycles; the fixed four-stage
    // fetch pipeline (read, data, font read, glyph) then lands each glyph
    // exactly on the cycle after the previous character's last pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            cr_rd        <= STROBE_OFF;
            cr_rd_addr   <= '0;
            font_rd      <= STROBE_OFF;
            font_rd_addr <= '0;
            pb_wr        <= STROBE_OFF;
            pb_wr_addr   <= '0;
            scan_q       <= '0;
            fcol         <= '0;
            gap          <= '0;
            fetch_p1     <= 1'b0;
            fetch_p2     <= 1'b0;
            fetch_p3     <= 1'b0;
            glyph_load   <= 1'b0;
            attr_q       <= '0;
            emit_col     <= '0;
        end else begin
            done       <= 1'b0;
            cr_rd      <= STROBE_OFF;
            font_rd    <= STROBE_OFF;
            fetch_p1   <= 1'b0;
            fetch_p2   <= fetch_p1;
            fetch_p3   <= fetch_p2;
            glyph_load <= fetch_p3;

            if (fetch_p2) begin
                font_rd      <= STROBE_ON;
                font_rd_addr <= {cr_rd_data[CODE_MSB:CODE_LSB], scan_q};
                attr_q       <= cr_rd_data[ATTR_MSB:ATTR_LSB];
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_PRIME;
                        busy       <= 1'b1;
                        scan_q     <= scanline & SL_MASK;
                        cr_rd      <= STROBE_ON;
                        cr_rd_addr <= '0;
                        fcol       <= 9'd1;
                        gap        <= GAP_RELOAD;
                        fetch_p1   <= 1'b1;
                    end
                end

                ST_PRIME, ST_EMIT: begin
                    if (gap != 4'd0) begin
                        gap <= gap - 4'd1;
                    end else if (fcol < COLS) begin
                        cr_rd      <= STROBE_ON;
                        cr_rd_addr <= fcol[7:0];
                        fcol       <= fcol + 9'd1;
                        gap        <= GAP_RELOAD;
                        fetch_p1   <= 1'b1;
                    end

                    if (state == ST_PRIME) begin
                        if (glyph_load) begin
                            state      <= ST_EMIT;
                            pb_wr      <= STROBE_ON;
                            pb_wr_addr <= '0;
                            emit_col   <= '0;
                        end
                    end else if (glyph_load) begin
                        emit_col   <= emit_col + 8'd1;
                        pb_wr_addr <= pb_wr_addr + PB_AW'(1);
                    end else if (last_px && emit_col == LAST_COL) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pb_wr <= STROBE_OFF;
                    end else begin
                        pb_wr_addr <= pb_wr_addr + PB_AW'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
